// File: rtl/bus_rr_router.sv
// Shared-bus router: round-robin pop from N terminal FIFOs, then route one
// packet per grant by destination ID (unicast, broadcast, or drop).
module bus_rr_router #(
    parameter int            drvrs      = 4,
    parameter int            pckg_sz    = 32,
    parameter int            id_w       = 8,
    parameter logic [id_w-1:0] broadcast = {id_w{1'b1}},
    parameter bit            bcast_self = 1'b0,
    parameter int            cnt_w      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [drvrs*pckg_sz-1:0]   D_push,
    output logic                       busy,
    output logic [cnt_w-1:0]           drop_cnt
);

    localparam int ptr_w = $clog2(drvrs);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ptr_w-1:0]   rr_ptr;
    logic [ptr_w-1:0]   sel;
    logic [ptr_w-1:0]   sel_nxt;
    logic [ptr_w-1:0]   arb_sel;
    logic               arb_found;
    logic [drvrs-1:0]   sel_oh;
    logic               sel_pndng;
    logic               load;
    logic [pckg_sz-1:0] head;
    logic [id_w-1:0]    dst;
    logic               is_uni;
    logic               is_bc;
    logic               drop;
    logic [drvrs-1:0]   push_nxt;

    // Rotating priority scan starting at rr_ptr
    always_comb begin
        arb_sel   = '0;
        arb_found = 1'b0;
        for (int k = 0; k < drvrs; k++) begin
            if (!arb_found && pndng[(int'(rr_ptr) + k) % drvrs]) begin
                arb_found = 1'b1;
                arb_sel   = ptr_w'((int'(rr_ptr) + k) % drvrs);
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        head   = '0;
        for (int i = 0; i < drvrs; i++) begin
            sel_oh[i] = (sel == ptr_w'(i));
            if (sel == ptr_w'(i)) begin
                head = D_pop[i*pckg_sz +: pckg_sz];
            end
        end
    end

    assign sel_pndng = |(pndng & sel_oh);
    assign dst       = head[pckg_sz-1 -: id_w];
    assign is_uni    = (32'(dst) < 32'(drvrs));
    assign is_bc     = (dst == broadcast);
    assign drop      = !is_uni && !is_bc;

    always_comb begin
        push_nxt = '0;
        for (int j = 0; j < drvrs; j++) begin
            if (is_uni) begin
                push_nxt[j] = (32'(dst) == 32'(j));
            end else if (is_bc) begin
                push_nxt[j] = bcast_self || (sel != ptr_w'(j));
            end
        end
    end

    // pop is qualified by the live pndng so a withdrawn request is never popped
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        pop       = '0;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (|pndng) begin
                    sel_nxt   = arb_sel;
                    state_nxt = POP;
                end
            end
            POP: begin
                if (sel_pndng) begin
                    pop       = sel_oh;
                    load      = 1'b1;
                    state_nxt = PUSH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            push     <= '0;
            D_push   <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            push  <= '0;
            if (load) begin
                push   <= push_nxt;
                D_push <= {drvrs{head}};
                rr_ptr <= (sel == ptr_w'(drvrs - 1)) ? '0 : sel + 1'b1;
                if (drop && !(&drop_cnt)) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_rr_router.sv
// Directed bench for bus_rr_router: default, broadcast-self and 2-bit
// counter variants driven from one FIFO model.
module tb_bus_rr_router;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   pndng;
    logic [127:0] D_pop;

    logic [3:0]   pop_a, push_a, pop_b, push_b, pop_c, push_c;
    logic [127:0] D_push_a, D_push_b, D_push_c;
    logic         busy_a, busy_b, busy_c;
    logic [15:0]  drop_a, drop_b;
    logic [1:0]   drop_c;

    always #5 clk = ~clk;

    bus_rr_router dut_a (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop_a), .push(push_a), .D_push(D_push_a),
        .busy(busy_a), .drop_cnt(drop_a)
    );

    bus_rr_router #(.bcast_self(1'b1)) dut_b (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop_b), .push(push_b), .D_push(D_push_b),
        .busy(busy_b), .drop_cnt(drop_b)
    );

    bus_rr_router #(.cnt_w(2)) dut_c (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop_c), .push(push_c), .D_push(D_push_c),
        .busy(busy_c), .drop_cnt(drop_c)
    );

    typedef struct {
        int          src;
        logic [31:0] pkt;
        logic [3:0]  exp_push;
        logic [3:0]  exp_push_bs;
        logic [15:0] exp_drop;
        logic [1:0]  exp_drop_c;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] q [4][$];
    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    bit          use_q = 1'b1;

    logic [3:0]   s_pop, s_push, s_push_b;
    logic [127:0] s_dpush;
    logic         s_busy;
    logic [15:0]  s_drop;
    logic [1:0]   s_drop_c;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            pndng[i] = (q[i].size() > 0);
            D_pop[i*32 +: 32] = (q[i].size() > 0) ? q[i][0] : 32'h0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        s_pop    = pop_a;
        s_push   = push_a;
        s_push_b = push_b;
        s_dpush  = D_push_a;
        s_busy   = busy_a;
        s_drop   = drop_a;
        s_drop_c = drop_c;
        chk("pop_push_excl", 128'((|pop_a) && (|push_a)), 128'(0));
        @(posedge clk);
        #1;
        cyc_n++;
        if (use_q) begin
            for (int i = 0; i < 4; i++) begin
                if (s_pop[i] && q[i].size() > 0) begin
                    void'(q[i].pop_front());
                end
            end
            drive();
        end
    endtask

    task automatic wait_pop(output logic [3:0] p, output int at);
        p  = '0;
        at = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (|s_pop) begin
                p  = s_pop;
                at = cyc_n;
                return;
            end
        end
        chk("pop_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        logic [3:0]  p;
        int          at;
        int          prev_at;
        logic [31:0] exp_pkt;

        vecs[0] = '{1, 32'h0300_00AA, 4'b1000, 4'b1000, 16'd0, 2'd0};
        vecs[1] = '{2, 32'hFF12_3456, 4'b1011, 4'b1111, 16'd0, 2'd0};
        vecs[2] = '{0, 32'h0700_0000, 4'b0000, 4'b0000, 16'd1, 2'd1};
        vecs[3] = '{3, 32'h0300_1234, 4'b1000, 4'b1000, 16'd1, 2'd1};
        vecs[4] = '{0, 32'h0000_0001, 4'b0001, 4'b0001, 16'd1, 2'd1};
        vecs[5] = '{1, 32'h0400_0000, 4'b0000, 4'b0000, 16'd2, 2'd2};
        vecs[6] = '{3, 32'hFE00_0000, 4'b0000, 4'b0000, 16'd3, 2'd3};
        vecs[7] = '{0, 32'hFF00_0000, 4'b1110, 4'b1111, 16'd3, 2'd3};
        vecs[8] = '{2, 32'h8000_0000, 4'b0000, 4'b0000, 16'd4, 2'd3};
        vecs[9] = '{1, 32'h1000_0000, 4'b0000, 4'b0000, 16'd5, 2'd3};

        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        cycle();
        cycle();
        chk("rst_pop", 128'(s_pop), 128'(0));
        chk("rst_push", 128'(s_push), 128'(0));
        chk("rst_dpush", s_dpush, 128'(0));
        chk("rst_busy", 128'(s_busy), 128'(0));
        chk("rst_drop", 128'(s_drop), 128'(0));
        reset = 1'b0;

        for (int v = 0; v < 10; v++) begin
            q[vecs[v].src].push_back(vecs[v].pkt);
            drive();
            cycle();
            chk("idle_pop", 128'(s_pop), 128'(0));
            cycle();
            chk("vec_pop", 128'(s_pop), 128'(4'b0001 << vecs[v].src));
            chk("vec_busy", 128'(s_busy), 128'(1));
            cycle();
            chk("vec_push", 128'(s_push), 128'(vecs[v].exp_push));
            chk("vec_push_bs", 128'(s_push_b), 128'(vecs[v].exp_push_bs));
            chk("vec_dpush", s_dpush, {4{vecs[v].pkt}});
            chk("vec_drop", 128'(s_drop), 128'(vecs[v].exp_drop));
            chk("vec_drop_sat", 128'(s_drop_c), 128'(vecs[v].exp_drop_c));
        end

        // Withdrawn request on terminal 3 while rr_ptr is 2
        use_q = 1'b0;
        pndng = 4'b1000;
        D_pop[96 +: 32] = 32'h0100_0000;
        cycle();
        pndng = 4'b0000;
        cycle();
        chk("wd_pop", 128'(s_pop), 128'(0));
        chk("wd_busy_pop", 128'(s_busy), 128'(1));
        cycle();
        chk("wd_push", 128'(s_push), 128'(0));
        chk("wd_busy_idle", 128'(s_busy), 128'(0));
        use_q = 1'b1;
        q[0].push_back(32'h0200_0000);
        q[2].push_back(32'h0200_0002);
        drive();
        wait_pop(p, at);
        chk("wd_rr_first", 128'(p), 128'(4'b0100));
        wait_pop(p, at);
        chk("wd_rr_second", 128'(p), 128'(4'b0001));
        cycle();
        chk("wd_push_last", 128'(s_push), 128'(4'b0100));
        cycle();

        // Reset held two cycles while a packet sits in PUSH
        q[1].push_back(32'h0300_00AA);
        drive();
        cycle();
        cycle();
        chk("mr_pop", 128'(s_pop), 128'(4'b0010));
        reset = 1'b1;
        cycle();
        chk("mr_push_before", 128'(s_push), 128'(4'b1000));
        cycle();
        chk("mr_push", 128'(s_push), 128'(0));
        chk("mr_busy", 128'(s_busy), 128'(0));
        chk("mr_dpush", s_dpush, 128'(0));
        chk("mr_drop", 128'(s_drop), 128'(0));
        chk("mr_drop_sat", 128'(s_drop_c), 128'(0));
        reset = 1'b0;
        cycle();
        chk("mr_push_after", 128'(s_push), 128'(0));

        // All terminals pending; order must restart at terminal 0
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 2; n++) begin
                q[i].push_back({8'h00, 24'(i * 16 + n)});
            end
        end
        drive();
        prev_at = 0;
        for (int k = 0; k < 8; k++) begin
            wait_pop(p, at);
            chk("rr_pop", 128'(p), 128'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk("rr_spacing", 128'(at - prev_at), 128'(3));
            end
            prev_at = at;
            exp_pkt = {8'h00, 24'((k % 4) * 16 + k / 4)};
            cycle();
            chk("rr_push", 128'(s_push), 128'(4'b0001));
            chk("rr_dpush", s_dpush, {4{exp_pkt}});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
